// File: rtl/rom_addr_sequencer.sv
// Sweeps every ROM address up or down, holds each one for HOLD_CYCLES cycles, then captures the word.
// The optional running checksum of captured words is enabled by defining CHECKSUM_EN.
module rom_addr_sequencer #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic              wrap_en,
  input  logic              stop,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] address,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              dir_reg, dir_next;
  logic              wrap_reg, wrap_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              valid_reg, valid_next;
  logic              sel_reg, sel_next;
  logic              done_reg, done_next;
  logic [ADDR_W-1:0] first_addr, last_addr;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next;
`endif

  // The start/end points of a sweep depend on the latched direction.
  assign first_addr = dir_reg ? ADDR_MAX : '0;
  assign last_addr  = dir_reg ? '0 : ADDR_MAX;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    wrap_next  = wrap_reg;
    dout_next  = dout_reg;
    valid_next = 1'b0;
`ifdef CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          dir_next   = dir;
          wrap_next  = wrap_en;
          addr_next  = dir ? ADDR_MAX : '0;
          cnt_next   = '0;
`ifdef CHECKSUM_EN
          sum_next   = '0;
`endif
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CAPTURE: begin
        // An abort wins over both the capture and the wrap-around.
        if (stop) begin
          state_next = IDLE;
        end else begin
          dout_next  = rom_data;
          valid_next = 1'b1;
`ifdef CHECKSUM_EN
          sum_next   = sum_reg + rom_data;
`endif
          if (addr_reg != last_addr) begin
            addr_next  = dir_reg ? addr_reg - 1'b1 : addr_reg + 1'b1;
            state_next = DRIVE;
          end else if (wrap_reg) begin
            addr_next  = first_addr;
            state_next = DRIVE;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    sel_next  = (state_next == DRIVE) || (state_next == CAPTURE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      sel_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      sel_reg   <= sel_next;
      done_reg  <= done_next;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_reg <= '0;
    else     sum_reg <= sum_next;
  end
  assign checksum = sum_reg;
`else
  assign checksum = '0;
`endif

  assign address    = addr_reg;
  assign sel        = sel_reg;
  assign busy       = sel_reg;
  assign done       = done_reg;
  assign dout       = dout_reg;
  assign dout_valid = valid_reg;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Bench for rom_addr_sequencer: two instances (HOLD_CYCLES 1 and 3) each driving a behavioural ROM,
// with a queue scoreboard on the captured words.
module tb_rom_addr_sequencer;

`ifdef CHECKSUM_EN
  localparam logic [7:0] EXP_CKS = 8'h1C;
`else
  localparam logic [7:0] EXP_CKS = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 0, dir1 = 0, wrap1 = 0, stop1 = 0;
  logic [7:0] rom1, dout1, cks1;
  logic [2:0] addr1;
  logic       sel1, dv1, busy1, done1;

  logic       start3 = 0, dir3 = 0, wrap3 = 0, stop3 = 0;
  logic [7:0] rom3, dout3, cks3;
  logic [2:0] addr3;
  logic       sel3, dv3, busy3, done3;

  int checks = 0;
  int errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];

  rom_addr_sequencer #(.ADDR_W(3), .DATA_W(8), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dir(dir1), .wrap_en(wrap1), .stop(stop1),
    .rom_data(rom1), .address(addr1), .sel(sel1), .dout(dout1), .dout_valid(dv1),
    .busy(busy1), .done(done1), .checksum(cks1));

  rom_addr_sequencer #(.ADDR_W(3), .DATA_W(8), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .dir(dir3), .wrap_en(wrap3), .stop(stop3),
    .rom_data(rom3), .address(addr3), .sel(sel3), .dout(dout3), .dout_valid(dv3),
    .busy(busy3), .done(done3), .checksum(cks3));

  function automatic logic [7:0] rom_model(input logic [2:0] a);
    return 8'hA5 ^ {5'b0, a};
  endfunction

  always_comb rom1 = sel1 ? rom_model(addr1) : 8'h00;
  always_comb rom3 = sel3 ? rom_model(addr3) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Scoreboards: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (dv1) begin
      if (q1.size() == 0) check("dut1_unexpected_valid", {24'b0, dout1}, 32'hFFFF_FFFF);
      else check("dut1_dout", {24'b0, dout1}, {24'b0, q1.pop_front()});
    end
    if (dv3) begin
      if (q3.size() == 0) check("dut3_unexpected_valid", {24'b0, dout3}, 32'hFFFF_FFFF);
      else check("dut3_dout", {24'b0, dout3}, {24'b0, q3.pop_front()});
    end
  end

  function automatic logic done_of(input int w);
    return (w == 0) ? done1 : done3;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy1 : busy3;
  endfunction
  function automatic logic [2:0] addr_of(input int w);
    return (w == 0) ? addr1 : addr3;
  endfunction
  function automatic logic [7:0] cks_of(input int w);
    return (w == 0) ? cks1 : cks3;
  endfunction
  function automatic int qsize_of(input int w);
    return (w == 0) ? q1.size() : q3.size();
  endfunction

  // Single-pass sweep; disturb adds start+stop on the accepted edge and a start pulse while busy.
  task automatic run_sweep(input int which, input logic d, input int exp_lat,
                           input logic [2:0] exp_addr, input bit disturb);
    logic [2:0] a;
    bit seen;
    a = d ? 3'd7 : 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (which == 0) q1.push_back(rom_model(a));
      else            q3.push_back(rom_model(a));
      a = d ? a - 3'd1 : a + 3'd1;
    end
    @(negedge clk);
    if (which == 0) begin
      start1 = 1; dir1 = d; wrap1 = 0;
      if (disturb) stop1 = 1;
    end else begin
      start3 = 1; dir3 = d; wrap3 = 0;
    end
    seen = 0;
    for (int n = 1; n <= exp_lat + 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start1 = 0; start3 = 0; stop1 = 0;
        check("cks_cleared_on_start", {24'b0, cks_of(which)}, 32'h0);
        check("busy_after_start", {31'b0, busy_of(which)}, 32'h1);
      end
      if (disturb && n == 4) begin start1 = 1; dir1 = ~d; end
      if (disturb && n == 9) start1 = 0;
      if (done_of(which)) begin
        seen = 1;
        check("done_latency", n, exp_lat);
        check("checksum_at_done", {24'b0, cks_of(which)}, {24'b0, EXP_CKS});
        break;
      end
    end
    if (!seen) check("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
    check("busy_after_done", {31'b0, busy_of(which)}, 32'h0);
    check("done_one_cycle", {31'b0, done_of(which)}, 32'h0);
    check("addr_holds_last", {29'b0, addr_of(which)}, {29'b0, exp_addr});
    check("scoreboard_drained", qsize_of(which), 0);
  endtask

  typedef struct {
    int         which;
    logic       dir;
    int         lat;
    logic [2:0] last_addr;
  } sweep_vec_t;

  sweep_vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    int nw;
    vecs[0] = '{which: 0, dir: 1'b0, lat: 17, last_addr: 3'd7};
    vecs[1] = '{which: 0, dir: 1'b1, lat: 17, last_addr: 3'd0};
    vecs[2] = '{which: 1, dir: 1'b1, lat: 33, last_addr: 3'd0};
    vecs[3] = '{which: 1, dir: 1'b0, lat: 33, last_addr: 3'd7};

    // Reset state
    @(negedge clk);
    check("rst_addr", {29'b0, addr1}, 32'h0);
    check("rst_sel_busy_done", {29'b0, sel1, busy1, done1}, 32'h0);
    check("rst_dout_valid", {23'b0, dout1, dv1}, 32'h0);
    check("rst_checksum", {24'b0, cks1}, 32'h0);
    @(negedge clk);
    rst = 0;

    // Up/down single passes for both hold settings
    for (int v = 0; v < 4; v++)
      run_sweep(vecs[v].which, vecs[v].dir, vecs[v].lat, vecs[v].last_addr, 1'b0);

    // Second up sweep: checksum clears on start and reaches the same total
    run_sweep(0, 1'b0, 17, 3'd7, 1'b0);

    // Continuous mode: 26 words without done, then stop in the DRIVE of address 2
    for (int i = 0; i < 26; i++) q1.push_back(rom_model(3'(i % 8)));
    @(negedge clk);
    start1 = 1; dir1 = 0; wrap1 = 1;
    done_seen = 0;
    nw = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin start1 = 0; wrap1 = 0; end
      if (done1) done_seen = 1;
      if (dv1) begin
        nw++;
        if (dout1 == rom_model(3'd7)) check("wrap_no_gap_addr", {28'b0, sel1, addr1}, {28'b0, 1'b1, 3'd0});
        if (nw == 26) break;
      end
    end
    check("wrap_word_count", nw, 26);
    check("wrap_addr_before_stop", {29'b0, addr1}, 32'd2);
    stop1 = 1;
    @(negedge clk);
    stop1 = 0;
    check("stop_busy", {30'b0, busy1, sel1}, 32'h0);
    check("stop_no_valid", {31'b0, dv1}, 32'h0);
    check("stop_addr_holds", {29'b0, addr1}, 32'd2);
    check("stop_dout_holds", {24'b0, dout1}, {24'b0, rom_model(3'd1)});
    check("wrap_no_done", {31'b0, done_seen}, 32'h0);
    repeat (6) @(negedge clk);
    check("stop_stays_idle", {31'b0, busy1}, 32'h0);

    // stop alone in IDLE changes nothing
    stop1 = 1;
    repeat (3) @(negedge clk);
    stop1 = 0;
    check("idle_stop_busy", {31'b0, busy1}, 32'h0);
    check("idle_stop_addr", {29'b0, addr1}, 32'd2);

    // Start+stop together in IDLE is accepted; start while busy is ignored
    run_sweep(0, 1'b0, 17, 3'd7, 1'b1);

    // Asynchronous reset during CAPTURE of address 4
    for (int i = 0; i < 4; i++) q1.push_back(rom_model(3'(i)));
    @(negedge clk);
    start1 = 1; dir1 = 0;
    nw = 0;
    for (int n = 1; n <= 50 && nw < 4; n++) begin
      @(negedge clk);
      if (n == 1) start1 = 0;
      if (dv1) nw++;
    end
    @(negedge clk);
    check("capture4_addr", {28'b0, dv1, addr1}, {28'b0, 1'b0, 3'd4});
    rst = 1;
    #1;
    check("async_rst_addr_sel", {27'b0, addr1, sel1, busy1}, 32'h0);
    check("async_rst_dout", {23'b0, dout1, dv1}, 32'h0);
    check("async_rst_done_cks", {23'b0, cks1, done1}, 32'h0);
    @(negedge clk);
    rst = 0;
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done1) done_seen = 1;
    end
    check("rst_no_done", {31'b0, done_seen}, 32'h0);
    check("rst_scoreboard", q1.size(), 0);
    run_sweep(0, 1'b0, 17, 3'd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
